// File: rtl/dsdac_pkg.sv
// -----------------------------------------------------------------------------
// dsdac_pkg
// Shared constants, types and helpers for the delta-sigma DAC front end.
//   SAMPLE_BITS_DEFAULT : width of unsigned audio samples
//   FRAC_EXT            : extra fractional bits carried by the interpolator
//   interp_state_t      : interpolator control state (IDLE / RAMP)
// -----------------------------------------------------------------------------
package dsdac_pkg;

  localparam int SAMPLE_BITS_DEFAULT     = 16;
  localparam int FRAC_EXT                = 7;
  localparam int OUT_BITS_DEFAULT        = SAMPLE_BITS_DEFAULT + FRAC_EXT;
  localparam int FIFO_DEPTH_LOG2_DEFAULT = 2;
  localparam int STEP_LOG2_BITS_DEFAULT  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } interp_state_t;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Small power-of-two FIFO with registered storage and wrapping pointers.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data at the tail (ignored when full)
//   push_data   : data to write
//   pop         : discard the head entry (ignored when empty)
//   head_data   : current head entry (valid when level != 0)
//   level       : occupancy, 0..2^DEPTH_LOG2
//   full        : level has reached the depth
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);

  localparam int                   DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  do_push, do_pop;

  assign full    = (level_q == LEVEL_FULL);
  assign do_push = push && !full;
  assign do_pop  = pop && (level_q != '0);

  // Pointers wrap naturally because the depth is a power of two.
  // NOTE: every variable driven from always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; level gates every read, so stale
  // entries are never observed and the array maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/sample_interpolator.sv
// -----------------------------------------------------------------------------
// sample_interpolator
// Buffers unsigned audio samples and ramps the modulator input u linearly from
// the current sample to the next over 2^s modulator pulses, one step per
// advance strobe. The ramp lands exactly on each target (no drift).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   in_valid        : sample offered on in_sample
//   in_ready        : FIFO can accept a sample this cycle
//   in_sample       : unsigned sample (midpoint 2^(SAMPLE_BITS-1))
//   step_log2       : log2 of pulses per segment, latched at segment start
//   advance         : one-cycle strobe from the modulator's pulse_done
//   u               : registered interpolated value for the modulator
//   fifo_level      : FIFO occupancy
//   underrun        : sticky, a segment ended with the FIFO empty
//   underrun_clear  : clears underrun (a simultaneous new underrun wins)
// -----------------------------------------------------------------------------
module sample_interpolator
  import dsdac_pkg::*;
#(
  parameter int SAMPLE_BITS     = SAMPLE_BITS_DEFAULT,
  parameter int OUT_BITS        = OUT_BITS_DEFAULT,
  parameter int FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEFAULT,
  parameter int STEP_LOG2_BITS  = STEP_LOG2_BITS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SAMPLE_BITS-1:0]     in_sample,
  input  logic [STEP_LOG2_BITS-1:0]  step_log2,
  input  logic                       advance,
  output logic [OUT_BITS-1:0]        u,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       underrun,
  input  logic                       underrun_clear
);

  localparam int FRAC_BITS = OUT_BITS - SAMPLE_BITS;
  localparam int ACC_BITS  = OUT_BITS + 1;
  localparam int S_MAX_INT = min_int(FRAC_BITS, (1 << STEP_LOG2_BITS) - 1);

  localparam logic [STEP_LOG2_BITS-1:0] S_MAX     = STEP_LOG2_BITS'(S_MAX_INT);
  localparam logic [7:0]                FRAC_SH   = 8'(FRAC_BITS);
  localparam logic [FRAC_BITS:0]        SPAN_ONE  = (FRAC_BITS + 1)'(1);
  localparam logic [FRAC_BITS-1:0]      PHASE_ONE = FRAC_BITS'(1);
  localparam logic [SAMPLE_BITS-1:0]    CUR_RESET = SAMPLE_BITS'(1) << (SAMPLE_BITS - 1);
  localparam logic [ACC_BITS-1:0]       ACC_RESET = ACC_BITS'(1) << (OUT_BITS - 1);

  // Control and datapath state.
  interp_state_t                state_q, state_d;
  logic signed [ACC_BITS-1:0]   acc_q, acc_d;
  logic signed [ACC_BITS-1:0]   inc_q, inc_d;
  logic [FRAC_BITS-1:0]         phase_q, phase_d;
  logic [STEP_LOG2_BITS-1:0]    s_q, s_d;
  logic [SAMPLE_BITS-1:0]       cur_q, cur_d;
  logic [SAMPLE_BITS-1:0]       target_q, target_d;
  logic                         underrun_q, underrun_d;

  // FIFO interface.
  logic                         fifo_push, fifo_pop, fifo_full;
  logic [SAMPLE_BITS-1:0]       fifo_head;
  logic [FIFO_DEPTH_LOG2:0]     fifo_level_w;

  // Decode shared by the next-state and datapath processes.
  logic                         fifo_nonempty;
  logic [FRAC_BITS:0]           span;
  logic                         last_step;
  logic                         seg_end;
  logic                         load;

  // Segment-load helpers.
  logic [STEP_LOG2_BITS-1:0]    s_new;
  logic signed [SAMPLE_BITS:0]  delta;
  logic signed [ACC_BITS-1:0]   delta_ext;
  logic [7:0]                   shamt;

  sample_fifo #(
    .WIDTH      (SAMPLE_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_sample),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .level     (fifo_level_w),
    .full      (fifo_full)
  );

  // No bypass: a full FIFO refuses pushes even when a pop happens this cycle.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = load;

  always_comb begin
    fifo_nonempty = (fifo_level_w != '0);
    span          = SPAN_ONE << s_q;
    last_step     = ({1'b0, phase_q} == (span - SPAN_ONE));
    seg_end       = (state_q == RAMP) && advance && last_step;
    load          = fifo_nonempty && ((state_q == IDLE) || seg_end);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load) state_d = RAMP;
      RAMP: if (seg_end && !fifo_nonempty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic.
  always_comb begin
    acc_d      = acc_q;
    inc_d      = inc_q;
    phase_d    = phase_q;
    s_d        = s_q;
    cur_d      = cur_q;
    target_d   = target_q;
    underrun_d = underrun_q;
    s_new      = (step_log2 > S_MAX) ? S_MAX : step_log2;
    shamt      = FRAC_SH - 8'(s_new);

    if ((state_q == RAMP) && advance) begin
      acc_d = acc_q + inc_q;
      if (last_step) cur_d = target_q;
      else           phase_d = phase_q + PHASE_ONE;
    end

    // NOTE: blocking assignments in combinational logic are read in order;
    // delta deliberately uses cur_d, i.e. the value the segment will start
    // from (the old target when chaining directly out of a finished segment).
    delta     = $signed({1'b0, fifo_head}) - $signed({1'b0, cur_d});
    delta_ext = {{FRAC_BITS{delta[SAMPLE_BITS]}}, delta};

    if (load) begin
      target_d = fifo_head;
      inc_d    = delta_ext << shamt;
      phase_d  = '0;
      s_d      = s_new;
    end

    // A new underrun outranks a simultaneous clear.
    if (underrun_clear)            underrun_d = 1'b0;
    if (seg_end && !fifo_nonempty) underrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= ACC_RESET;
      inc_q      <= '0;
      phase_q    <= '0;
      s_q        <= '0;
      cur_q      <= CUR_RESET;
      target_q   <= CUR_RESET;
      underrun_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      phase_q    <= phase_d;
      s_q        <= s_d;
      cur_q      <= cur_d;
      target_q   <= target_d;
      underrun_q <= underrun_d;
    end
  end

  // acc never leaves [0, 2^OUT_BITS), so the sign bit is dropped on output.
  assign u          = acc_q[OUT_BITS-1:0];
  assign fifo_level = fifo_level_w;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_sample_interpolator.sv
// -----------------------------------------------------------------------------
// tb_sample_interpolator
// Directed and randomized stimulus for sample_interpolator. A reference model
// keeps the FIFO as a queue and computes u arithmetically as
//   cur*128 + (target-cur) * k * 2^(7-s)
// where k is the number of steps taken in the current segment.
// -----------------------------------------------------------------------------
module tb_sample_interpolator;

  localparam int SB  = 16;
  localparam int OB  = 23;
  localparam int FL  = 2;
  localparam int SLB = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SB-1:0]   in_sample = '0;
  logic [SLB-1:0]  step_log2 = '0;
  logic            advance = 1'b0;
  logic [OB-1:0]   u;
  logic [FL:0]     fifo_level;
  logic            underrun;
  logic            underrun_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int mq[$];
  int m_cur, m_tgt, m_k, m_s;
  bit m_ramp, m_urun;

  always #5 clk = ~clk;

  sample_interpolator dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sample      (in_sample),
    .step_log2      (step_log2),
    .advance        (advance),
    .u              (u),
    .fifo_level     (fifo_level),
    .underrun       (underrun),
    .underrun_clear (underrun_clear)
  );

  function automatic int model_u();
    if (!m_ramp) return m_cur * 128;
    return m_cur * 128 + (m_tgt - m_cur) * m_k * (1 << (7 - m_s));
  endfunction

  task automatic model_edge(input bit v, input int smp, input int st,
                            input bit adv, input bit clr, input bit rst);
    int  size0;
    bit  load, set_ur;
    if (rst) begin
      mq.delete();
      m_cur = 32'h8000; m_tgt = 32'h8000; m_k = 0; m_s = 0;
      m_ramp = 0; m_urun = 0;
      return;
    end
    size0  = mq.size();
    load   = 0;
    set_ur = 0;
    if (!m_ramp) begin
      load = (size0 > 0);
    end else if (adv) begin
      if (m_k == (1 << m_s) - 1) begin
        m_cur = m_tgt;
        m_k   = 0;
        if (size0 > 0) load = 1;
        else begin m_ramp = 0; set_ur = 1; end
      end else begin
        m_k++;
      end
    end
    if (load) begin
      m_tgt  = mq.pop_front();
      m_k    = 0;
      m_s    = (st > 7) ? 7 : st;
      m_ramp = 1;
    end
    if (v && size0 < 4) mq.push_back(smp & 32'hFFFF);
    if (set_ur)   m_urun = 1;
    else if (clr) m_urun = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, clock, update the model, compare 1 time unit later.
  task automatic tick(input bit v, input int smp, input int st,
                      input bit adv, input bit clr, input bit rst);
    in_valid       = v;
    in_sample      = smp[SB-1:0];
    step_log2      = st[SLB-1:0];
    advance        = adv;
    underrun_clear = clr;
    reset          = rst;
    @(posedge clk);
    model_edge(v, smp, st, adv, clr, rst);
    #1;
    check("model.u",          32'(u),          32'(model_u()));
    check("model.fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("model.in_ready",   32'(in_ready),   32'(mq.size() < 4));
    check("model.underrun",   32'(underrun),   32'(m_urun));
  endtask

  initial begin
    int smp[6];
    int r_v, r_adv, r_clr, r_rst, r_st;

    // Reset and idle behaviour.
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    check("reset.u",          32'(u),          32'h400000);
    check("reset.in_ready",   32'(in_ready),   32'd1);
    check("reset.fifo_level", 32'(fifo_level), 32'd0);
    check("reset.underrun",   32'(underrun),   32'd0);
    repeat (3) tick(0, 0, 0, 1, 0, 0);
    check("idle_adv.u",        32'(u),        32'h400000);
    check("idle_adv.underrun", 32'(underrun), 32'd0);

    // Up-ramp over 4 pulses.
    tick(1, 32'h8100, 2, 0, 0, 0);
    check("up.level_after_push", 32'(fifo_level), 32'd1);
    tick(0, 0, 2, 0, 0, 0);
    check("up.level_after_load", 32'(fifo_level), 32'd0);
    check("up.u_before_adv",     32'(u),          32'h400000);
    tick(0, 0, 2, 1, 0, 0); check("up.u1", 32'(u), 32'h402000);
    tick(0, 0, 2, 1, 0, 0); check("up.u2", 32'(u), 32'h404000);
    tick(0, 0, 2, 1, 0, 0); check("up.u3", 32'(u), 32'h406000);
    tick(0, 0, 2, 1, 0, 0); check("up.u4", 32'(u), 32'h408000);
    check("up.underrun", 32'(underrun), 32'd1);
    repeat (2) tick(0, 0, 2, 1, 0, 0);
    check("up.hold_u", 32'(u), 32'h408000);
    tick(0, 0, 2, 0, 1, 0);
    check("up.clear", 32'(underrun), 32'd0);

    // Down-ramp with a single-pulse segment, then back to midpoint.
    tick(1, 32'h7F00, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("down.u1", 32'(u), 32'h3F8000);
    tick(1, 32'h8000, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("down.u2", 32'(u), 32'h400000);
    tick(0, 0, 0, 0, 1, 0);

    // Full FIFO: six back-to-back offers without advance.
    foreach (smp[i]) smp[i] = $urandom_range(0, 65535);
    for (int i = 0; i < 5; i++) tick(1, smp[i], 1, 0, 0, 0);
    check("full.level",    32'(fifo_level), 32'd4);
    check("full.in_ready", 32'(in_ready),   32'd0);
    repeat (2) tick(1, smp[5], 1, 0, 0, 0);
    check("full.stall_level", 32'(fifo_level), 32'd4);
    tick(0, 0, 1, 1, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    check("full.pop_level", 32'(fifo_level), 32'd3);
    tick(0, 0, 1, 1, 0, 0);
    tick(1, smp[5], 1, 1, 0, 0);
    check("full.push_pop_level", 32'(fifo_level), 32'd3);
    repeat (12) tick(0, 0, 1, 1, 0, 0);
    check("full.drain_u",        32'(u),        32'(smp[5] * 128));
    check("full.drain_underrun", 32'(underrun), 32'd1);

    // New underrun coincident with clear: set wins; clear alone clears.
    tick(1, $urandom_range(0, 65535), 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 0);
    check("urun.set_wins", 32'(underrun), 32'd1);
    tick(0, 0, 0, 0, 1, 0);
    check("urun.clear", 32'(underrun), 32'd0);

    // Reset mid-ramp (s = 7, phase 40) with samples still buffered.
    tick(1, 32'h8123, 7, 0, 0, 0);
    tick(1, 32'h9000, 7, 0, 0, 0);
    tick(1, 32'h7000, 7, 0, 0, 0);
    repeat (40) tick(0, 0, 7, 1, 0, 0);
    tick(0, 0, 7, 0, 0, 1);
    check("midreset.u",     32'(u),          32'h400000);
    check("midreset.level", 32'(fifo_level), 32'd0);
    tick(0, 0, 7, 0, 0, 0);
    tick(1, 32'h8080, 7, 0, 0, 0);
    tick(0, 0, 7, 0, 0, 0);
    repeat (127) tick(0, 0, 7, 1, 0, 0);
    check("long.u127", 32'(u), 32'h403F80);
    tick(0, 0, 7, 1, 0, 0);
    check("long.u128", 32'(u), 32'h404000);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      r_v   = ($urandom_range(0, 99) < 45);
      r_adv = ($urandom_range(0, 99) < 60);
      r_clr = ($urandom_range(0, 99) < 5);
      r_rst = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      tick(r_v[0], $urandom_range(0, 65535), r_st, r_adv[0], r_clr[0], r_rst[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
